// File: rtl/line_clear_pkg.sv
// Shared definitions for the line-clear stage: board geometry defaults, the
// (row,col) -> bit index mapping, FSM state encoding and the points table.
package line_clear_pkg;

  // Board geometry defaults, identical to those used by move_piece.
  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Row 0 is the top of the board; columns are packed LSB-first within a row.
  function automatic int unsigned bit_idx(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned cols);
    return row * cols + col;
  endfunction

  // Points awarded for clearing n rows in a single landing.
  function automatic logic [3:0] pts(input int unsigned n);
    case (n)
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd3;
      3:       return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/line_clear_row_collapse.sv
// Combinational row test and collapse: reports whether the selected row is
// full and produces the board with that row removed and everything above it
// shifted down by one, a zero row entering at the top.
module row_collapse
  import line_clear_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  localparam int ROW_W = $clog2(ROWS),
  localparam int N     = ROWS * COLS
) (
  input  logic [N-1:0]     board_i,
  input  logic [ROW_W-1:0] row_i,
  output logic             row_full_o,
  output logic [N-1:0]     board_o
);

  assign row_full_o = &board_i[bit_idx(32'(row_i), 0, COLS) +: COLS];

  // Rows 1..row_i take the row above; rows below row_i pass through.
  always_comb begin
    // NOTE: a full default before the conditional loop keeps every bit assigned on every path, so no latch is inferred.
    board_o = board_i;
    for (int unsigned r = 1; r < ROWS; r++) begin
      if (r <= 32'(row_i)) begin
        board_o[bit_idx(r, 0, COLS) +: COLS] = board_i[bit_idx(r - 1, 0, COLS) +: COLS];
      end
    end
    board_o[COLS-1:0] = '0;
  end

endmodule

// File: rtl/line_clear.sv
// Line-clear stage: after a piece lands, scans the settled board bottom-up,
// collapses every full row, then reports the cleaned board, rows cleared,
// a saturating running score and a sticky game-over flag.
module line_clear
  import line_clear_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int SCORE_W = 8,
  localparam int N      = ROWS * COLS,
  localparam int ROW_W  = $clog2(ROWS),
  localparam int CNT_W  = $clog2(ROWS + 1)
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       board_in,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       board_out,
  output logic [2:0]         lines,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  state_t             state_q;
  logic [N-1:0]       work_q;
  logic [ROW_W-1:0]   row_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [N-1:0]       board_q;
  logic [2:0]         lines_q;
  logic [SCORE_W-1:0] score_q;
  logic               go_q;

  logic               row_full;
  logic [N-1:0]       collapsed;
  logic [2:0]         lines_d;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_d;

  row_collapse #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_collapse (
    .board_i    (work_q),
    .row_i      (row_q),
    .row_full_o (row_full),
    .board_o    (collapsed)
  );

  // Result values for the FINISH step: saturated line count and score.
  always_comb begin
    lines_d   = (cnt_q > CNT_W'(7)) ? 3'd7 : cnt_q[2:0];
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts(32'(cnt_q)));
    score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // Control FSM with registered outputs; a full row is re-checked after the collapse.
  always_ff @(posedge clka) begin
    if (reset) begin
      // NOTE: the working board is cleared on reset as well, so an aborted scan leaves no stale rows behind.
      state_q <= ST_IDLE;
      work_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      board_q <= '0;
      lines_q <= '0;
      score_q <= '0;
      go_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q  <= board_in;
            row_q   <= ROW_W'(ROWS - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (row_full) begin
            work_q <= collapsed;
            cnt_q  <= cnt_q + 1'b1;
          end else if (row_q == '0) begin
            state_q <= ST_FINISH;
          end else begin
            row_q <= row_q - 1'b1;
          end
        end
        ST_FINISH: begin
          board_q <= work_q;
          lines_q <= lines_d;
          score_q <= score_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          if (|work_q[COLS-1:0]) go_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign board_out = board_q;
  assign lines     = lines_q;
  assign score     = score_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_line_clear.sv
// Scoreboard bench for line_clear: two instances (8-bit and 4-bit score)
// share stimulus; a driver pushes expected results from a row-list model and
// a monitor pops and compares on every done pulse, including its timing.
module tb_line_clear;

  localparam int ROWS = 8;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic         clka = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] board_in;

  logic         busy, done, game_over;
  logic [N-1:0] board_out;
  logic [2:0]   lines;
  logic [7:0]   score;

  logic         busy_s, done_s, game_over_s;
  logic [N-1:0] board_out_s;
  logic [2:0]   lines_s;
  logic [3:0]   score_s;

  line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(8)) dut (
    .clka(clka), .reset(reset), .start(start), .board_in(board_in),
    .busy(busy), .done(done), .board_out(board_out), .lines(lines),
    .score(score), .game_over(game_over)
  );

  line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(4)) dut_s (
    .clka(clka), .reset(reset), .start(start), .board_in(board_in),
    .busy(busy_s), .done(done_s), .board_out(board_out_s), .lines(lines_s),
    .score(score_s), .game_over(game_over_s)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] board;
    int           lines;
    int           s8;
    int           s4;
    int           go;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state kept by the driver.
  int s8_m = 0;
  int s4_m = 0;
  int go_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pts_m(input int k);
    if (k >= 4) return 8;
    if (k == 3) return 5;
    if (k == 2) return 3;
    return k;
  endfunction

  // Remove full rows, keep the others in order, pad with empty rows at the top.
  function automatic void model(input logic [N-1:0] b, output logic [N-1:0] res, output int k);
    logic [COLS-1:0] keep[$];
    logic [COLS-1:0] nib;
    int base;
    k = 0;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      nib = b[r*COLS +: COLS];
      if (nib == '1) k++;
      else keep.push_back(nib);
    end
    base = ROWS - keep.size();
    for (int i = 0; i < keep.size(); i++) res[(base + i)*COLS +: COLS] = keep[i];
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_done"},  32'(done),       0);
    check({tag, "_board"}, board_out,       0);
    check({tag, "_lines"}, 32'(lines),      0);
    check({tag, "_score"}, 32'(score),      0);
    check({tag, "_go"},    32'(game_over),  0);
    check({tag, "_s_board"}, board_out_s,   0);
    check({tag, "_s_score"}, 32'(score_s),  0);
    check({tag, "_s_go"},    32'(game_over_s), 0);
  endtask

  // Called right after a negedge; leaves on a negedge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clka);
    check_zero_outputs(tag);
    reset = 1'b0;
    s8_m = 0;
    s4_m = 0;
    go_m = 0;
  endtask

  task automatic do_op(input logic [N-1:0] b, input bit glitch_mid, input bit glitch_done);
    exp_t e;
    logic [N-1:0] res;
    int k;
    model(b, res, k);
    s8_m = (s8_m + pts_m(k) > 255) ? 255 : s8_m + pts_m(k);
    s4_m = (s4_m + pts_m(k) > 15)  ? 15  : s4_m + pts_m(k);
    if (res[COLS-1:0] != '0) go_m = 1;
    e.board = res;
    e.lines = (k > 7) ? 7 : k;
    e.s8    = s8_m;
    e.s4    = s4_m;
    e.go    = go_m;
    e.cyc   = cyc + 2 + ROWS + k;
    exp_q.push_back(e);
    start    = 1'b1;
    board_in = b;
    @(negedge clka);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    if (glitch_mid) begin
      start    = 1'b1;
      board_in = ~b;
      @(negedge clka);
      start = 1'b0;
    end
    if (glitch_done) begin
      while (cyc < e.cyc - 1) @(negedge clka);
      start    = 1'b1;
      board_in = 32'hFFFF_FFFF;
      @(negedge clka);
      start = 1'b0;
    end
    while (cyc < e.cyc + 1) @(negedge clka);
  endtask

  // Start an op and assert reset so it is sampled on the third edge after start.
  task automatic abort_op(input logic [N-1:0] b);
    start    = 1'b1;
    board_in = b;
    @(negedge clka);
    start = 1'b0;
    @(negedge clka);
    @(negedge clka);
    do_reset("abort");
    repeat (14) @(negedge clka);
  endtask

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] b;
    for (int r = 0; r < ROWS; r++) begin
      if ($urandom_range(2) == 0) b[r*COLS +: COLS] = '1;
      else b[r*COLS +: COLS] = COLS'($urandom_range(14));
    end
    return b;
  endfunction

  // Monitor: pop and compare on each done pulse; flag missing or extra pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clka);
      if (done || done_s) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done || done_s), 0);
        end else begin
          e = exp_q.pop_front();
          check("done",        32'(done),        1);
          check("done_s",      32'(done_s),      1);
          check("done_cycle",  32'(cyc),         32'(e.cyc));
          check("busy_at_done", 32'(busy),       0);
          check("board_out",   board_out,        e.board);
          check("lines",       32'(lines),       32'(e.lines));
          check("score",       32'(score),       32'(e.s8));
          check("game_over",   32'(game_over),   32'(e.go));
          check("board_out_s", board_out_s,      e.board);
          check("lines_s",     32'(lines_s),     32'(e.lines));
          check("score_s",     32'(score_s),     32'(e.s4));
          check("game_over_s", 32'(game_over_s), 32'(e.go));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        check("done_timeout", 32'(done), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    board_in = '0;
    @(negedge clka);
    do_reset("reset");

    do_op(32'h0000_0000, 0, 0);
    do_op(32'hF000_0000, 0, 0);
    do_op(32'hF0F0_0100, 0, 0);
    do_op(32'h0000_0002, 0, 0);
    do_op(32'h0000_0000, 0, 0);
    check("go_sticky", 32'(game_over), 1);
    do_op(32'h0F0F_000F, 1, 0);
    do_op(32'hF000_0000, 0, 1);
    do_reset("reset2");

    abort_op(32'hFFF0_0000);
    do_op(32'h0F00_F100, 0, 0);
    do_reset("reset3");

    do_op(32'hFFFF_FFFF, 0, 0);
    do_op(32'hFFFF_FFFF, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(rand_board(), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (30) @(negedge clka);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
- Stage directly downstream of move_piece. Once a piece has landed, it takes the settled 32-bit board (move_piece's new_board_state) and removes every full row, collapsing the rows above.
- Reports lines cleared, keeps a running score and raises a sticky game-over flag. The cleaned board feeds back as curr_board_state for the next piece spawn.
- Board layout is shared with move_piece: bit index = row*COLS + col; row 0 is the top; row ROWS-1 is the bottom (bits 28..31).

Parameters:
- ROWS, 8, number of board rows.
- COLS, 4, number of board columns; a row is full when all COLS bits are 1.
- SCORE_W, 8, width of the score accumulator.

Ports:
- clka  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to process board_in; accepted only when idle.
- board_in  input  ROWS*COLS  settled board after landing.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; board_out/lines/score valid from this cycle.
- board_out  output  ROWS*COLS  board after clearing; held until next done.
- lines  output  3  rows cleared by the last operation (0..ROWS, saturate at 7).
- score  output  SCORE_W  running score, saturating.
- game_over  output  1  sticky; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, including board_out, score and game_over. Internal state returns to IDLE with the working board = 0. Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: if start=1, load work<=board_in, row<=ROWS-1, cnt<=0, busy<=1, go to SCAN. start is ignored in all other states.
  - SCAN, one row per cycle:
    - If work row `row` is full: in the same cycle, rows 1..row take old rows 0..row-1, row 0 becomes 0, rows below `row` are unchanged. cnt<=cnt+1 and `row` is not decremented, so the shifted-in row is re-checked.
    - Else if row==0: go to FINISH.
    - Else: row<=row-1.
  - FINISH: board_out<=work; lines<=cnt (saturating); score<=sat(score+pts(cnt)); done<=1 for exactly one cycle; busy<=0; go to IDLE.
    - If any bit of row 0 of work is 1, game_over<=1.
- Points table pts: 0->0, 1->1, 2->3, 3->5, >=4->8. Additions saturate at 2^SCORE_W-1 and never wrap.
- Latency: with start sampled at edge E0 and k rows cleared, SCAN occupies edges E1..E(ROWS+k) and done is registered at edge E(ROWS+k+1). For an empty board with ROWS=8, done is registered at E9.
- A full row 0: it is cleared (shifted in as zero) and re-scanned. The scan ends only after row 0 is found not full.
- An all-ones board clears ROWS rows. lines saturates at 7 and pts uses the >=4 entry.
- start asserted on the same edge as done is ignored; start must be reasserted while in IDLE.
- game_over does not block further operations; the controller decides.

Decomposition:
- Shared package holds:
  - ROWS/COLS defaults shared with move_piece;
  - the bit-index mapping function (row,col)->index;
  - the FSM state encoding (IDLE, SCAN, FINISH);
  - the pts lookup function.
- One natural combinational sub-module, row_collapse: inputs are the board and a row index; outputs are the row_full flag and the collapsed board. Everything else stays in line_clear.

Test Plan:
- Empty board: board_in=0x00000000, start -> done registered at E9, board_out=0, lines=0, score=0, game_over=0.
- Single bottom row: board_in=0xF0000000 -> board_out=0x00000000, lines=1, score=1, done at E10.
- Two non-adjacent rows plus debris: board_in=0xF0F00100 -> board_out=0x00010000, lines=2, score +3, done at E11.
- Top-row occupancy: board_in=0x00000002 -> lines=0, board_out=0x00000002, game_over=1. game_over stays 1 through a later empty-board op and clears only after reset.
- Busy rules: assert start again during SCAN with a different board_in -> ignored, result matches the first board. Assert reset at E3 of an op -> all outputs 0, no done pulse, next start works normally.
- Saturation: SCORE_W=4, apply the all-ones board 0xFFFFFFFF twice -> lines=7 each time, score=8 then 15 (saturated, no wrap).
